// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package mul_pkg;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

endpackage : mul_pkg

// File: rtl/seq_mul_fsm.sv
// Control for seq_mul: state register, iteration counter, busy/done decode.
module seq_mul_fsm
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_flush,
    output logic o_accept,
    output logic o_run,
    output logic o_busy,
    output logic o_done
);

    mul_state_t       r_state;
    mul_state_t       w_next;
    logic [CNT_W-1:0] r_count;

    // NOTE: state and counters use non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (o_accept)
                r_count <= '0;
            else if (o_run)
                r_count <= r_count + 1'b1;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next   = r_state;
        o_accept = 1'b0;
        o_run    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start && !i_flush) begin
                    w_next   = RUN;
                    o_accept = 1'b1;
                end
            end
            RUN: begin
                if (i_flush) begin
                    w_next = IDLE;
                end else begin
                    o_run = 1'b1;
                    if (r_count == CNT_W'(WIDTH - 1))
                        w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = (r_state == DONE);

endmodule : seq_mul_fsm

// File: rtl/seq_mul.sv
// Radix-2 shift-add multiplier producing the low word and a register-file write-back.
// Define SEQ_MUL_ACC_EN to add the op_acc/acc_en ports for MLA accumulate.
module seq_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef SEQ_MUL_ACC_EN
    input  logic [WIDTH-1:0] op_acc,
    input  logic             acc_en,
`endif
    input  logic [3:0]       rd_in,
    input  logic             s_in,
    output logic             busy,
    output logic             done,
    output logic             we,
    output logic [3:0]       wa,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z
);

    logic             w_accept;
    logic             w_run;
    logic             w_busy;
    logic             w_done;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [3:0]       r_wa;
    logic             r_s;

    seq_mul_fsm #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (start),
        .i_flush  (flush),
        .o_accept (w_accept),
        .o_run    (w_run),
        .o_busy   (w_busy),
        .o_done   (w_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_wa     <= '0;
            r_s      <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_wa     <= rd_in;
            r_s      <= s_in;
`ifdef SEQ_MUL_ACC_EN
            r_acc    <= acc_en ? op_acc : '0;
`else
            r_acc    <= '0;
`endif
        end else if (w_run) begin
            // Sum wraps modulo 2^WIDTH; only the low word is architecturally visible.
            if (r_mplier[0])
                r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign busy   = w_busy;
    assign done   = w_done;
    assign we     = w_done;
    assign wa     = r_wa;
    assign result = r_acc;
    assign flag_n = w_done & r_s & r_acc[WIDTH-1];
    assign flag_z = w_done & r_s & (r_acc == '0);

endmodule : seq_mul

// File: tb/tb_seq_mul.sv
// Directed self-checking bench for seq_mul; covers the MLA path when SEQ_MUL_ACC_EN is defined.
module tb_seq_mul;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         flush;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
`ifdef SEQ_MUL_ACC_EN
    logic [W-1:0] op_acc;
    logic         acc_en;
`endif
    logic [3:0]   rd_in;
    logic         s_in;
    logic         busy;
    logic         done;
    logic         we;
    logic [3:0]   wa;
    logic [W-1:0] result;
    logic         flag_n;
    logic         flag_z;

    int errors = 0;
    int checks = 0;
    int cyc;
    int pulses;

    seq_mul dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .op_a   (op_a),
        .op_b   (op_b),
`ifdef SEQ_MUL_ACC_EN
        .op_acc (op_acc),
        .acc_en (acc_en),
`endif
        .rd_in  (rd_in),
        .s_in   (s_in),
        .busy   (busy),
        .done   (done),
        .we     (we),
        .wa     (wa),
        .result (result),
        .flag_n (flag_n),
        .flag_z (flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns at the first negedge after acceptance (cycle 1).
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] rd, input logic s);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        rd_in = rd;
        s_in  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Advance negedge by negedge until done is seen or the budget runs out.
    task automatic wait_done(input int base, output int n);
        n = base;
        while (!done && n < base + 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_we(input int span, output int n);
        n = 0;
        for (int i = 0; i < span; i++) begin
            @(negedge clk);
            if (we) n++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op_a  = '0;
        op_b  = '0;
        rd_in = '0;
        s_in  = 1'b0;
`ifdef SEQ_MUL_ACC_EN
        op_acc = '0;
        acc_en = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy",   busy,   0);
        chk("rst_done",   done,   0);
        chk("rst_we",     we,     0);
        chk("rst_wa",     wa,     0);
        chk("rst_result", result, 0);
        chk("rst_flags",  {flag_n, flag_z}, 0);
        rst_n = 1'b1;

        // 7 x 6 -> 42, latency 33, one-cycle write-back to r3
        launch(32'd7, 32'd6, 4'd3, 1'b0);
        chk("mul7x6_busy", busy, 1);
        wait_done(1, cyc);
        chk("mul7x6_latency", cyc, 33);
        chk("mul7x6_result",  result, 32'd42);
        chk("mul7x6_wa",      wa, 3);
        chk("mul7x6_we",      we, 1);
        chk("mul7x6_busy_done", busy, 1);
        @(negedge clk);
        chk("mul7x6_we_one_cycle", we, 0);
        chk("mul7x6_idle", busy, 0);

        // all-ones squared wraps to 1
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 1'b1);
        wait_done(1, cyc);
        chk("ones_result", result, 32'h0000_0001);
        chk("ones_n", flag_n, 0);
        chk("ones_z", flag_z, 0);

        launch(32'h8000_0000, 32'd1, 4'd4, 1'b1);
        wait_done(1, cyc);
        chk("msb_result", result, 32'h8000_0000);
        chk("msb_n", flag_n, 1);
        chk("msb_z", flag_z, 0);

        launch(32'd0, 32'd5, 4'd5, 1'b1);
        wait_done(1, cyc);
        chk("zero_result", result, 0);
        chk("zero_z", flag_z, 1);
        chk("zero_n", flag_n, 0);

        // flags are forced low when s_in was clear
        launch(32'd0, 32'd5, 4'd5, 1'b0);
        wait_done(1, cyc);
        chk("zero_nos_z", flag_z, 0);

        // start during RUN is ignored; original result and timing stand
        launch(32'h0000_1234, 32'h0000_0010, 4'd2, 1'b0);
        repeat (9) @(negedge clk);
        op_a  = 32'd9;
        op_b  = 32'd9;
        rd_in = 4'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(11, cyc);
        chk("ignore_latency", cyc, 33);
        chk("ignore_result",  result, 32'h0001_2340);
        chk("ignore_wa",      wa, 2);
        count_we(40, pulses);
        chk("ignore_no_second_done", pulses, 0);

        // flush mid-RUN aborts with no write-back
        launch(32'h0000_ABCD, 32'h0000_0077, 4'd6, 1'b0);
        repeat (15) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", busy, 0);
        chk("flush_no_done", done, 0);
        count_we(40, pulses);
        chk("flush_no_we", pulses, 0);

        // flush together with start in IDLE produces no acceptance
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_idle", busy, 0);

        launch(32'd3, 32'd3, 4'd8, 1'b0);
        wait_done(1, cyc);
        chk("after_flush_latency", cyc, 33);
        chk("after_flush_result", result, 32'd9);

        // asynchronous reset mid-RUN clears outputs at once
        launch(32'd5, 32'd5, 4'd9, 1'b1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy",   busy, 0);
        chk("midrst_result", result, 0);
        chk("midrst_wa",     wa, 0);
        chk("midrst_we",     we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        launch(32'd2, 32'd3, 4'd10, 1'b0);
        wait_done(1, cyc);
        chk("after_rst_result", result, 32'd6);

`ifdef SEQ_MUL_ACC_EN
        op_acc = 32'd5;
        acc_en = 1'b1;
        launch(32'd3, 32'd4, 4'd11, 1'b0);
        acc_en = 1'b0;
        wait_done(1, cyc);
        chk("mla_result", result, 32'd17);
        chk("mla_latency", cyc, 33);
        launch(32'd3, 32'd4, 4'd11, 1'b0);
        wait_done(1, cyc);
        chk("mul_ignores_acc", result, 32'd12);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_mul
